// File: rtl/serial_digit_rx_pkg.sv
// Shared constants for the digit serial link: frame geometry, digit codes,
// receiver FSM states and the pin/edge indices used by the receiver.
package serial_digit_rx_pkg;

  localparam int N_DIGITS_DEF    = 8;
  localparam int DIGIT_W_DEF     = 4;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  // Synchronized pins
  localparam int PIN_SCLK = 0;
  localparam int PIN_DEN  = 1;
  localparam int PIN_SDI  = 2;
  localparam int PIN_DCLK = 3;
  localparam int N_PINS   = 4;

  // Pins that also carry an edge detector
  localparam int EDG_SCLK = 0;
  localparam int EDG_DEN  = 1;
  localparam int EDG_DCLK = 2;
  localparam int N_EDGES  = 3;

endpackage

// File: rtl/serial_digit_rx_if.sv
// Link pins in, display drive and frame status out, grouped for the receiver.
interface serial_digit_rx_if
  import serial_digit_rx_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int DIGIT_W  = DIGIT_W_DEF
);
  localparam int FRAME_W = N_DIGITS * DIGIT_W;

  logic                sclk_in;
  logic                den_in;
  logic                sdi;
  logic                dclk_in;
  logic [6:0]          seg;
  logic [N_DIGITS-1:0] dig_en;
  logic [FRAME_W-1:0]  rx_data;
  logic                frame_done;
  logic                frame_err;

  modport master (
    output sclk_in, den_in, sdi, dclk_in,
    input  seg, dig_en, rx_data, frame_done, frame_err
  );

  modport slave (
    input  sclk_in, den_in, sdi, dclk_in,
    output seg, dig_en, rx_data, frame_done, frame_err
  );
endinterface

// File: rtl/serial_digit_rx_seg7_decode.sv
// Combinational digit code to 7-segment glyph (bit0=a .. bit6=g, active-high).
module seg7_decode
  import serial_digit_rx_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    o_seg = 7'h00;
    case (i_code)
      4'h0:      o_seg = 7'h3F;
      4'h1:      o_seg = 7'h06;
      4'h2:      o_seg = 7'h5B;
      4'h3:      o_seg = 7'h4F;
      4'h4:      o_seg = 7'h66;
      4'h5:      o_seg = 7'h6D;
      4'h6:      o_seg = 7'h7D;
      4'h7:      o_seg = 7'h07;
      4'h8:      o_seg = 7'h7F;
      4'h9:      o_seg = 7'h6F;
      DIG_MINUS: o_seg = 7'h40;
      default:   o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/serial_digit_rx.sv
// Receive end of the digit serial link: captures sclk/den/sdi frames into a
// display register and scans it onto a multiplexed 7-segment display.
module serial_digit_rx
  import serial_digit_rx_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEF,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
)(
  input  logic            clk,
  input  logic            rst,
  serial_digit_rx_if.slave bus
);

  localparam int FRAME_W = N_DIGITS * DIGIT_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detectors
  // ---------------------------------------------------------------------------
  logic [N_PINS-1:0]      w_pin;
  logic [N_PINS-1:0]      w_sync;
  logic [N_EDGES-1:0]     w_edge_sync;
  logic [N_EDGES-1:0]     w_rise;
  logic                   w_den_fall;
  logic [SYNC_STAGES-1:0] r_fill;

  assign w_pin[PIN_SCLK] = bus.sclk_in;
  assign w_pin[PIN_DEN]  = bus.den_in;
  assign w_pin[PIN_SDI]  = bus.sdi;
  assign w_pin[PIN_DCLK] = bus.dclk_in;

  // r_fill marks when the synchronizers hold real pin values again after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= '0;
    end else begin
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  generate
    for (genvar g = 0; g < N_PINS; g++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[g]};
        end
      end

      assign w_sync[g] = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_edge_sync[EDG_SCLK] = w_sync[PIN_SCLK];
  assign w_edge_sync[EDG_DEN]  = w_sync[PIN_DEN];
  assign w_edge_sync[EDG_DCLK] = w_sync[PIN_DCLK];

  generate
    for (genvar e = 0; e < N_EDGES; e++) begin : g_edge
      logic r_prev;
      logic r_armed;

      // A rise only counts once the pin has been seen low after reset, so a
      // line already high when reset releases is not mistaken for an edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_prev  <= 1'b0;
          r_armed <= 1'b0;
        end else begin
          r_prev <= w_edge_sync[e];
          if (r_fill[SYNC_STAGES-1] && !w_edge_sync[e]) begin
            r_armed <= 1'b1;
          end
        end
      end

      assign w_rise[e] = r_armed & w_edge_sync[e] & ~r_prev;

      if (e == EDG_DEN) begin : g_fall
        assign w_den_fall = ~w_edge_sync[e] & r_prev;
      end
    end
  endgenerate

  logic w_sclk_rise;
  logic w_den_rise;
  logic w_dclk_rise;
  logic w_sdi_s;

  assign w_sclk_rise = w_rise[EDG_SCLK];
  assign w_den_rise  = w_rise[EDG_DEN];
  assign w_dclk_rise = w_rise[EDG_DCLK];
  assign w_sdi_s     = w_sync[PIN_SDI];

  // ---------------------------------------------------------------------------
  // Frame receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e          r_state,   w_state_nxt;
  logic [CNT_W-1:0]   r_bitcnt,  w_bitcnt_nxt;
  logic               r_ovr,     w_ovr_nxt;
  logic [FRAME_W-1:0] r_shreg,   w_shreg_nxt;
  logic [FRAME_W-1:0] r_rx_data, w_rx_data_nxt;
  logic               r_done,    w_done_nxt;
  logic               r_err,     w_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= '0;
      r_ovr     <= 1'b0;
      r_shreg   <= '0;
      r_rx_data <= {N_DIGITS{DIG_BLANK}};
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_ovr     <= w_ovr_nxt;
      r_shreg   <= w_shreg_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_ovr_nxt     = r_ovr;
    w_shreg_nxt   = r_shreg;
    w_rx_data_nxt = r_rx_data;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_bitcnt_nxt = '0;
        w_ovr_nxt    = 1'b0;
        if (w_den_rise && !w_den_fall) begin
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // The den fall takes priority: a coincident sclk rise is dropped.
        if (w_den_fall) begin
          w_state_nxt  = ST_IDLE;
          w_bitcnt_nxt = '0;
          w_ovr_nxt    = 1'b0;
          if (r_bitcnt == FULL_CNT && !r_ovr) begin
            w_rx_data_nxt = r_shreg;
            w_done_nxt    = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_sclk_rise) begin
          if (r_bitcnt == FULL_CNT) begin
            w_ovr_nxt = 1'b1;
          end else begin
            w_shreg_nxt  = {r_shreg[FRAME_W-2:0], w_sdi_s};
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit scan and registered segment decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]    r_idx;
  logic [N_DIGITS-1:0] r_dig_en;
  logic [6:0]          r_seg;
  logic [DIGIT_W-1:0]  w_nibble;
  logic [6:0]          w_seg;

  assign w_nibble = r_rx_data[r_idx*DIGIT_W +: DIGIT_W];

  seg7_decode u_seg7_decode (
    .i_code (w_nibble),
    .o_seg  (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_dig_en <= N_DIGITS'(1);
      r_seg    <= 7'h00;
    end else begin
      if (w_dclk_rise) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      r_dig_en <= N_DIGITS'(1) << r_idx;
      r_seg    <= w_seg;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dig_en     = r_dig_en;
  assign bus.rx_data    = r_rx_data;
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;

endmodule

// File: tb/tb_serial_digit_rx.sv
// Directed bench for serial_digit_rx: a frame-level model of the display
// register and scan index, checked every cycle, plus literal expectations.
module tb_serial_digit_rx;

  logic clk;
  logic rst;

  serial_digit_rx_if bus ();

  serial_digit_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: last good frame and scan position.
  logic [31:0] exp_rx;
  int          exp_idx;
  logic        check_en = 1'b0;
  int          done_cnt = 0;
  int          err_cnt  = 0;

  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  logic [7:0] walk_tab [9] = '{
    8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.frame_done) done_cnt++;
    if (bus.frame_err)  err_cnt++;
  end

  // Continuous comparison against the model whenever outputs are settled.
  always @(negedge clk) begin
    if (check_en) begin
      check("rx_data", bus.rx_data, exp_rx);
      check("dig_en", {24'h0, bus.dig_en}, 32'(8'h01 << exp_idx));
      check("seg", {25'h0, bus.seg}, {25'h0, glyph_tab[exp_rx[exp_idx*4 +: 4]]});
    end
  end

  task automatic send_bits(input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.sdi = val[i];
      tick(4);
      bus.sclk_in = 1'b1;
      tick(4);
      bus.sclk_in = 1'b0;
      tick(2);
    end
  endtask

  // Frame of n bits; it is good exactly when n equals the frame width.
  task automatic run_frame(input string name, input logic [63:0] bits, input int n);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    bus.den_in = 1'b1;
    tick(6);
    send_bits(bits, n);
    check_en = 1'b0;
    bus.den_in = 1'b0;
    tick(12);
    if (n == 32) exp_rx = bits[31:0];
    check({name, "_done"}, 32'(done_cnt - d0), (n == 32) ? 32'd1 : 32'd0);
    check({name, "_err"},  32'(err_cnt - e0),  (n == 32) ? 32'd0 : 32'd1);
    check_en = 1'b1;
    tick(4);
  endtask

  task automatic dclk_step();
    check_en = 1'b0;
    bus.dclk_in = 1'b1;
    tick(8);
    exp_idx = (exp_idx + 1) % 8;
    check_en = 1'b1;
    bus.dclk_in = 1'b0;
    tick(6);
  endtask

  initial begin
    int d0, e0;
    rst         = 1'b1;
    bus.sclk_in = 1'b0;
    bus.den_in  = 1'b0;
    bus.sdi     = 1'b0;
    bus.dclk_in = 1'b0;
    exp_rx      = 32'hFFFF_FFFF;
    exp_idx     = 0;
    tick(4);
    rst = 1'b0;

    check("rst_rx_data", bus.rx_data, 32'hFFFF_FFFF);
    check("rst_dig_en", {24'h0, bus.dig_en}, 32'h01);
    check("rst_seg", {25'h0, bus.seg}, 32'h00);
    check("rst_done", {31'h0, bus.frame_done}, 32'h0);
    check("rst_err", {31'h0, bus.frame_err}, 32'h0);
    tick(6);
    check_en = 1'b1;

    // Scan walk with wrap
    for (int k = 0; k < 9; k++) begin
      dclk_step();
      check("walk_dig_en", {24'h0, bus.dig_en}, {24'h0, walk_tab[k]});
    end

    run_frame("good1", 64'h0123_4567, 32);
    check("good1_rx", bus.rx_data, 32'h0123_4567);

    run_frame("short31", 64'h0765_4321 >> 1, 31);
    check("short31_rx", bus.rx_data, 32'h0123_4567);

    run_frame("long33", 64'h1_5555_AAAA, 33);
    check("long33_rx", bus.rx_data, 32'h0123_4567);

    run_frame("good2", 64'hAFFF_FF12, 32);
    check("good2_rx", bus.rx_data, 32'hAFFF_FF12);

    // idx is 1 after the walk; advance to 7, then 0, then 1
    for (int k = 0; k < 6; k++) dclk_step();
    check("seg_idx7", {25'h0, bus.seg}, 32'h40);
    dclk_step();
    check("seg_idx0", {25'h0, bus.seg}, 32'h5B);
    dclk_step();
    check("seg_idx1", {25'h0, bus.seg}, 32'h06);

    // Reset in the middle of a frame
    d0 = done_cnt;
    e0 = err_cnt;
    bus.den_in = 1'b1;
    tick(6);
    send_bits(64'h1234_5678, 16);
    check_en = 1'b0;
    rst = 1'b1;
    tick(1);
    check("midrst_rx_data", bus.rx_data, 32'hFFFF_FFFF);
    check("midrst_dig_en", {24'h0, bus.dig_en}, 32'h01);
    check("midrst_seg", {25'h0, bus.seg}, 32'h00);
    check("midrst_done", {31'h0, bus.frame_done}, 32'h0);
    check("midrst_err", {31'h0, bus.frame_err}, 32'h0);
    rst = 1'b0;
    exp_rx  = 32'hFFFF_FFFF;
    exp_idx = 0;
    tick(4);
    bus.den_in = 1'b0;
    tick(12);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    check_en = 1'b1;
    run_frame("after_rst", 64'h9876_5432, 32);
    check("after_rst_rx", bus.rx_data, 32'h9876_5432);

    // sclk rise on bit 33 coincident with den fall: edge dropped, frame good
    d0 = done_cnt;
    e0 = err_cnt;
    bus.den_in = 1'b1;
    tick(6);
    send_bits(64'h89AB_CDE0, 32);
    bus.sdi = 1'b1;
    tick(4);
    check_en = 1'b0;
    bus.sclk_in = 1'b1;
    bus.den_in  = 1'b0;
    tick(12);
    bus.sclk_in = 1'b0;
    exp_rx = 32'h89AB_CDE0;
    check("coinc_done", 32'(done_cnt - d0), 32'd1);
    check("coinc_err", 32'(err_cnt - e0), 32'd0);
    check("coinc_rx", bus.rx_data, 32'h89AB_CDE0);
    check_en = 1'b1;
    tick(8);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
